// File: rtl/exe_stage_unit_if.sv
// exe_stage_unit_if
//   Bundles the ID/EXE-side inputs and the EXE/MEM-side outputs of the
//   execute stage.
//   master : upstream pipeline / hazard logic. It drives the decoded
//            instruction and observes the stage results.
//   slave  : the execute stage itself.
//   Signals:
//     freeze, flush, valid_in, exe_cmd[3:0]
//     mem_read_in, mem_write_in, wb_en_in, b_in, s_in
//     val_rn, val2, val_rm, pc_in (WIDTH)
//     imm24[23:0], dest_in[3:0]
//     alu_result_q, store_data_q (WIDTH), dest_q[3:0]
//     valid_q, wb_en_q, mem_read_q, mem_write_q
//     status[3:0] (NZCV)
//     branch_taken, branch_addr (WIDTH)
interface exe_stage_unit_if #(
   parameter int WIDTH = 32
);
   logic             freeze;
   logic             flush;
   logic             valid_in;
   logic [3:0]       exe_cmd;
   logic             mem_read_in;
   logic             mem_write_in;
   logic             wb_en_in;
   logic             b_in;
   logic             s_in;
   logic [WIDTH-1:0] val_rn;
   logic [WIDTH-1:0] val2;
   logic [WIDTH-1:0] val_rm;
   logic [WIDTH-1:0] pc_in;
   logic [23:0]      imm24;
   logic [3:0]       dest_in;

   logic [WIDTH-1:0] alu_result_q;
   logic [WIDTH-1:0] store_data_q;
   logic [3:0]       dest_q;
   logic             valid_q;
   logic             wb_en_q;
   logic             mem_read_q;
   logic             mem_write_q;
   logic [3:0]       status;
   logic             branch_taken;
   logic [WIDTH-1:0] branch_addr;

   modport master (
      output freeze, flush, valid_in, exe_cmd, mem_read_in, mem_write_in,
             wb_en_in, b_in, s_in, val_rn, val2, val_rm, pc_in, imm24, dest_in,
      input  alu_result_q, store_data_q, dest_q, valid_q, wb_en_q,
             mem_read_q, mem_write_q, status, branch_taken, branch_addr
   );

   modport slave (
      input  freeze, flush, valid_in, exe_cmd, mem_read_in, mem_write_in,
             wb_en_in, b_in, s_in, val_rn, val2, val_rm, pc_in, imm24, dest_in,
      output alu_result_q, store_data_q, dest_q, valid_q, wb_en_q,
             mem_read_q, mem_write_q, status, branch_taken, branch_addr
   );
endinterface

// File: rtl/exe_stage_unit.sv
// exe_stage_unit
//   Execute stage of the five-stage ARM-subset pipeline. It runs the ALU
//   operation, owns the NZCV status register, computes the branch target,
//   and registers results and controls into the EXE/MEM register.
//   Ports:
//     clk  : rising-edge clock
//     rst  : asynchronous active-high reset
//     bus  : exe_stage_unit_if.slave, holding all stage inputs and outputs
module exe_stage_unit #(
   parameter int WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   exe_stage_unit_if.slave       bus
);
   localparam logic [3:0] CMD_MOV = 4'b0001;
   localparam logic [3:0] CMD_MVN = 4'b1001;
   localparam logic [3:0] CMD_ADD = 4'b0010;
   localparam logic [3:0] CMD_ADC = 4'b0011;
   localparam logic [3:0] CMD_SUB = 4'b0100;
   localparam logic [3:0] CMD_SBC = 4'b0101;
   localparam logic [3:0] CMD_AND = 4'b0110;
   localparam logic [3:0] CMD_ORR = 4'b0111;
   localparam logic [3:0] CMD_EOR = 4'b1000;

   logic [WIDTH-1:0] alu_result_reg, store_data_reg;
   logic [3:0]       dest_reg;
   logic             valid_reg, wb_en_reg, mem_read_reg, mem_write_reg;
   logic [3:0]       status_reg;

   logic [WIDTH-1:0] res;
   logic [WIDTH:0]   sum;
   logic             c_next, v_next, cmd_known;
   logic [3:0]       status_next;
   logic             status_we;

   logic [WIDTH-1:0] a, b;
   logic             c_cur;

   assign a     = bus.val_rn;
   assign b     = bus.val2;
   assign c_cur = status_reg[1];

   // ALU. Arithmetic runs one bit wider so that the carry/borrow lands in sum[WIDTH].
   always_comb begin
      res       = '0;
      sum       = '0;
      c_next    = status_reg[1];
      v_next    = status_reg[0];
      cmd_known = 1'b1;
      case (bus.exe_cmd)
         CMD_MOV: res = b;
         CMD_MVN: res = ~b;
         CMD_ADD, CMD_ADC: begin
            sum    = {1'b0, a} + {1'b0, b} +
                     {{WIDTH{1'b0}}, (bus.exe_cmd == CMD_ADC) & c_cur};
            res    = sum[WIDTH-1:0];
            c_next = sum[WIDTH];
            v_next = (a[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
         end
         CMD_SUB, CMD_SBC: begin
            sum    = {1'b0, a} - {1'b0, b} -
                     {{WIDTH{1'b0}}, (bus.exe_cmd == CMD_SBC) & ~c_cur};
            res    = sum[WIDTH-1:0];
            // C is the inverted borrow.
            c_next = ~sum[WIDTH];
            v_next = (a[WIDTH-1] != b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
         end
         CMD_AND: res = a & b;
         CMD_ORR: res = a | b;
         CMD_EOR: res = a ^ b;
         default: begin
            res       = '0;
            cmd_known = 1'b0;
         end
      endcase
      status_next = {res[WIDTH-1], (res == '0), c_next, v_next};
   end

   assign status_we = bus.valid_in & bus.s_in & ~bus.freeze & ~bus.flush & cmd_known;

   // Branch target: the word offset is sign-extended and scaled to bytes.
   assign bus.branch_addr  = bus.pc_in + {{(WIDTH-26){bus.imm24[23]}}, bus.imm24, 2'b00};
   assign bus.branch_taken = bus.valid_in & bus.b_in & ~bus.flush & ~bus.freeze;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_result_reg <= '0;
         store_data_reg <= '0;
         dest_reg       <= '0;
         valid_reg      <= 1'b0;
         wb_en_reg      <= 1'b0;
         mem_read_reg   <= 1'b0;
         mem_write_reg  <= 1'b0;
         status_reg     <= '0;
      end else if (bus.freeze) begin
         // Freeze wins over flush; the hazard logic re-asserts flush afterwards.
         alu_result_reg <= alu_result_reg;
         store_data_reg <= store_data_reg;
         dest_reg       <= dest_reg;
         valid_reg      <= valid_reg;
         wb_en_reg      <= wb_en_reg;
         mem_read_reg   <= mem_read_reg;
         mem_write_reg  <= mem_write_reg;
         status_reg     <= status_reg;
      end else if (bus.flush) begin
         alu_result_reg <= '0;
         store_data_reg <= '0;
         dest_reg       <= '0;
         valid_reg      <= 1'b0;
         wb_en_reg      <= 1'b0;
         mem_read_reg   <= 1'b0;
         mem_write_reg  <= 1'b0;
      end else begin
         alu_result_reg <= res;
         store_data_reg <= bus.val_rm;
         dest_reg       <= bus.dest_in;
         valid_reg      <= bus.valid_in;
         wb_en_reg      <= bus.wb_en_in & bus.valid_in;
         mem_read_reg   <= bus.mem_read_in & bus.valid_in;
         mem_write_reg  <= bus.mem_write_in & bus.valid_in;
         if (status_we) begin
            status_reg <= status_next;
         end
      end
   end

   assign bus.alu_result_q = alu_result_reg;
   assign bus.store_data_q = store_data_reg;
   assign bus.dest_q       = dest_reg;
   assign bus.valid_q      = valid_reg;
   assign bus.wb_en_q      = wb_en_reg;
   assign bus.mem_read_q   = mem_read_reg;
   assign bus.mem_write_q  = mem_write_reg;
   assign bus.status       = status_reg;
endmodule

// File: tb/tb_exe_stage_unit.sv
// tb_exe_stage_unit
//   Directed vector table for the ALU and flags, followed by hand-written
//   sequences for branch, flush, freeze, and asynchronous reset.
module tb_exe_stage_unit;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   exe_stage_unit_if #(.WIDTH(32)) bus ();

   exe_stage_unit #(.WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  cmd;
      logic        s;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_res;
      logic [3:0]  exp_nzcv;
   } vec_t;

   vec_t vecs[13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.freeze = 0; bus.flush = 0; bus.valid_in = 0; bus.exe_cmd = 0;
      bus.mem_read_in = 0; bus.mem_write_in = 0; bus.wb_en_in = 0;
      bus.b_in = 0; bus.s_in = 0; bus.val_rn = 0; bus.val2 = 0; bus.val_rm = 0;
      bus.pc_in = 0; bus.imm24 = 0; bus.dest_in = 0;
   endtask

   task automatic drive_alu(input logic [3:0] cmd, input logic s,
                            input logic [31:0] a, input logic [31:0] b);
      bus.valid_in = 1; bus.exe_cmd = cmd; bus.s_in = s;
      bus.val_rn = a; bus.val2 = b;
   endtask

   initial begin
      // Table entries are applied in order, so the flags carry from one
      // vector to the next.
      vecs[0]  = '{4'b0001, 1'b1, 32'h0,        32'h0,        32'h00000000, 4'b0100}; // MOV 0
      vecs[1]  = '{4'b0010, 1'b1, 32'h7FFFFFFF, 32'h1,        32'h80000000, 4'b1001}; // ADD ovf
      vecs[2]  = '{4'b0100, 1'b1, 32'd3,        32'd5,        32'hFFFFFFFE, 4'b1000}; // SUB 3-5
      vecs[3]  = '{4'b0101, 1'b1, 32'd10,       32'd2,        32'h00000007, 4'b0010}; // SBC C=0
      vecs[4]  = '{4'b0011, 1'b0, 32'd1,        32'd1,        32'h00000003, 4'b0010}; // ADC C=1, no S
      vecs[5]  = '{4'b0010, 1'b1, 32'h80000000, 32'h80000001, 32'h00000001, 4'b0011}; // ADD C,V
      vecs[6]  = '{4'b0110, 1'b1, 32'hF0,       32'h0F,       32'h00000000, 4'b0111}; // AND keeps CV
      vecs[7]  = '{4'b0111, 1'b0, 32'hF0,       32'h0F,       32'h000000FF, 4'b0111}; // ORR no S
      vecs[8]  = '{4'b1000, 1'b1, 32'hFF,       32'h0F,       32'h000000F0, 4'b0011}; // EOR
      vecs[9]  = '{4'b1001, 1'b1, 32'h0,        32'h0,        32'hFFFFFFFF, 4'b1011}; // MVN
      vecs[10] = '{4'b0100, 1'b1, 32'd5,        32'd3,        32'h00000002, 4'b0010}; // SUB 5-3
      vecs[11] = '{4'b0000, 1'b1, 32'd5,        32'd3,        32'h00000000, 4'b0010}; // undefined
      vecs[12] = '{4'b0101, 1'b1, 32'd5,        32'd5,        32'h00000000, 4'b0110}; // SBC C=1

      idle_inputs();
      #2;
      chk("reset_result", bus.alu_result_q, 32'h0);
      chk("reset_valid", {31'b0, bus.valid_q}, 32'h0);
      chk("reset_status", {28'b0, bus.status}, 32'h0);
      @(negedge clk);
      rst = 0;

      for (int i = 0; i < 13; i++) begin
         @(negedge clk);
         idle_inputs();
         drive_alu(vecs[i].cmd, vecs[i].s, vecs[i].a, vecs[i].b);
         bus.dest_in = 4'(i);
         bus.val_rm  = 32'hA5A50000 + 32'(i);
         @(posedge clk); #1;
         $display("vec %0d cmd=%b s=%b a=%08h b=%08h -> res=%08h nzcv=%b",
                  i, vecs[i].cmd, vecs[i].s, vecs[i].a, vecs[i].b,
                  bus.alu_result_q, bus.status);
         chk($sformatf("vec%0d_res", i), bus.alu_result_q, vecs[i].exp_res);
         chk($sformatf("vec%0d_nzcv", i), {28'b0, bus.status}, {28'b0, vecs[i].exp_nzcv});
         chk($sformatf("vec%0d_dest", i), {28'b0, bus.dest_q}, 32'(i));
         chk($sformatf("vec%0d_store", i), bus.store_data_q, 32'hA5A50000 + 32'(i));
         chk($sformatf("vec%0d_valid", i), {31'b0, bus.valid_q}, 32'h1);
      end
      // Status is now 0110.

      // Branch: combinational target and taken, then suppressed by flush.
      @(negedge clk);
      idle_inputs();
      bus.valid_in = 1; bus.b_in = 1; bus.pc_in = 32'h100; bus.imm24 = 24'hFFFFFE;
      bus.exe_cmd = 4'b0010; bus.val_rn = 32'd7; bus.val2 = 32'd8;
      #1;
      $display("branch pc=100 imm=FFFFFE -> addr=%08h taken=%b", bus.branch_addr, bus.branch_taken);
      chk("branch_addr", bus.branch_addr, 32'hF8);
      chk("branch_taken", {31'b0, bus.branch_taken}, 32'h1);
      bus.flush = 1; bus.s_in = 1;
      #1;
      chk("branch_flush_taken", {31'b0, bus.branch_taken}, 32'h0);
      @(posedge clk); #1;
      $display("flush -> valid_q=%b res=%08h nzcv=%b", bus.valid_q, bus.alu_result_q, bus.status);
      chk("flush_valid_q", {31'b0, bus.valid_q}, 32'h0);
      chk("flush_result", bus.alu_result_q, 32'h0);
      chk("flush_status", {28'b0, bus.status}, 32'h6);

      // Bubble: neither branches nor writes flags.
      @(negedge clk);
      bus.flush = 0; bus.valid_in = 0; bus.b_in = 1; bus.s_in = 1;
      bus.wb_en_in = 1; bus.exe_cmd = 4'b0100; bus.val_rn = 32'd3; bus.val2 = 32'd5;
      #1;
      chk("bubble_taken", {31'b0, bus.branch_taken}, 32'h0);
      @(posedge clk); #1;
      $display("bubble -> valid_q=%b wb_en_q=%b nzcv=%b", bus.valid_q, bus.wb_en_q, bus.status);
      chk("bubble_status", {28'b0, bus.status}, 32'h6);
      chk("bubble_wb_en", {31'b0, bus.wb_en_q}, 32'h0);

      // Freeze: capture a known ADD, then hold for 3 cycles with an S-ADD pending.
      @(negedge clk);
      idle_inputs();
      drive_alu(4'b0010, 1'b0, 32'd1, 32'd2);
      bus.dest_in = 4'd9;
      @(posedge clk); #1;
      chk("pre_freeze_res", bus.alu_result_q, 32'd3);
      @(negedge clk);
      drive_alu(4'b0010, 1'b1, 32'h7FFFFFFF, 32'h1);
      bus.dest_in = 4'd2; bus.b_in = 1; bus.freeze = 1;
      #1;
      chk("freeze_taken", {31'b0, bus.branch_taken}, 32'h0);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         $display("freeze cycle %0d -> res=%08h dest=%0d nzcv=%b", k, bus.alu_result_q, bus.dest_q, bus.status);
         chk($sformatf("freeze%0d_res", k), bus.alu_result_q, 32'd3);
         chk($sformatf("freeze%0d_dest", k), {28'b0, bus.dest_q}, 32'd9);
         chk($sformatf("freeze%0d_status", k), {28'b0, bus.status}, 32'h6);
      end
      @(negedge clk);
      bus.flush = 1;
      @(posedge clk); #1;
      $display("freeze+flush -> valid_q=%b res=%08h", bus.valid_q, bus.alu_result_q);
      chk("frzflush_valid", {31'b0, bus.valid_q}, 32'h1);
      chk("frzflush_res", bus.alu_result_q, 32'd3);
      @(negedge clk);
      bus.freeze = 0; bus.flush = 0; bus.b_in = 0;
      @(posedge clk); #1;
      $display("release -> res=%08h nzcv=%b", bus.alu_result_q, bus.status);
      chk("release_res", bus.alu_result_q, 32'h80000000);
      chk("release_status", {28'b0, bus.status}, 32'h9);

      // LDR captured, then asynchronous reset in the middle of the cycle.
      @(negedge clk);
      idle_inputs();
      drive_alu(4'b0010, 1'b0, 32'h1000, 32'h4);
      bus.mem_read_in = 1; bus.wb_en_in = 1; bus.dest_in = 4'd5;
      @(posedge clk); #1;
      chk("ldr_mem_read", {31'b0, bus.mem_read_q}, 32'h1);
      chk("ldr_addr", bus.alu_result_q, 32'h1004);
      #2;
      rst = 1;
      bus.b_in = 1;
      #1;
      $display("async rst -> mem_read_q=%b wb_en_q=%b valid_q=%b nzcv=%b taken=%b",
               bus.mem_read_q, bus.wb_en_q, bus.valid_q, bus.status, bus.branch_taken);
      chk("arst_mem_read", {31'b0, bus.mem_read_q}, 32'h0);
      chk("arst_wb_en", {31'b0, bus.wb_en_q}, 32'h0);
      chk("arst_valid", {31'b0, bus.valid_q}, 32'h0);
      chk("arst_status", {28'b0, bus.status}, 32'h0);
      chk("arst_taken", {31'b0, bus.branch_taken}, 32'h1);
      @(negedge clk);
      rst = 0; bus.b_in = 0;
      @(posedge clk); #1;
      chk("post_rst_capture", bus.alu_result_q, 32'h1004);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
